// File: rtl/decode_issue_if.sv
// decode_issue_if: fetch, execute, writeback and control signals of the decode/issue stage
interface decode_issue_if #(
   parameter int DATAW = 32,
   parameter int PCW   = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [PCW-1:0]   in_pc;
   logic             ex_valid;
   logic             ex_ready;
   logic             ex_alu_op;
   logic             ex_branch;
   logic             ex_use_imm;
   logic [1:0]       ex_shift_dist;
   logic [10:0]      ex_imm;
   logic [DATAW-1:0] ex_a;
   logic [DATAW-1:0] ex_b;
   logic [PCW-1:0]   ex_pc;
   logic [3:0]       ex_rd;
   logic             wb_en;
   logic [3:0]       wb_addr;
   logic [DATAW-1:0] wb_data;
   logic             flush;
   logic             halted;
   logic             illegal;

   modport master (
      output in_valid, in_instr, in_pc, ex_ready, wb_en, wb_addr, wb_data, flush,
      input  in_ready, ex_valid, ex_alu_op, ex_branch, ex_use_imm, ex_shift_dist, ex_imm,
             ex_a, ex_b, ex_pc, ex_rd, halted, illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, ex_ready, wb_en, wb_addr, wb_data, flush,
      output in_ready, ex_valid, ex_alu_op, ex_branch, ex_use_imm, ex_shift_dist, ex_imm,
             ex_a, ex_b, ex_pc, ex_rd, halted, illegal
   );
endinterface

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage with register file, RAW scoreboard, flush and halt.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data into decode.
module decode_issue #(
   parameter int DATAW = 32,
   parameter int PCW   = 32,
   parameter int NREG  = 16
) (
   input logic           clk,
   input logic           rst_n,
   decode_issue_if.slave bus
);
   typedef enum logic {RUN, HALTED} state_t;

`ifdef DECODE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   state_t           state_q;
   logic             halted_q;
   logic             illegal_q;
   logic [DATAW-1:0] rf_q [NREG];
   logic [NREG-1:0]  pending_q;
   logic [NREG-1:0]  pending_d;
   logic [NREG-1:0]  wb_mask;
   logic [NREG-1:0]  pend_eff;
   logic             ex_valid_q;
   logic             ex_wr_q;
   logic             alu_op_q;
   logic             branch_q;
   logic             use_imm_q;
   logic [1:0]       shift_q;
   logic [10:0]      imm_q;
   logic [DATAW-1:0] a_q;
   logic [DATAW-1:0] b_q;
   logic [PCW-1:0]   pc_q;
   logic [3:0]       ex_rd_q;

   logic [3:0]       op, rd, ra, rb, a_addr;
   logic             is_alu, is_ldi, is_br, is_halt, is_illegal, is_bundle, is_wr;
   logic             busy_a, busy_b, hazard, in_ready, xfer, consume;
   logic [DATAW-1:0] val_a, val_b;
   logic             unused_instr;

   assign op           = bus.in_instr[31:28];
   assign rd           = bus.in_instr[27:24];
   assign ra           = bus.in_instr[23:20];
   assign rb           = bus.in_instr[19:16];
   assign unused_instr = ^bus.in_instr[13:11];
   assign is_alu       = (op == 4'd1) || (op == 4'd2);
   assign is_ldi       = (op == 4'd3);
   assign is_br        = (op == 4'd4);
   assign is_halt      = (op == 4'd5);
   assign is_illegal   = (op > 4'd5);
   assign is_bundle    = is_alu || is_ldi || is_br;
   assign is_wr        = is_alu || is_ldi;

   // Source operand reads and RAW hazard detection against scoreboard and the bundle in flight
   always_comb begin
      a_addr   = is_ldi ? rd : ra;
      wb_mask  = (BYP && bus.wb_en) ? (NREG'(1) << bus.wb_addr) : '0;
      pend_eff = pending_q & ~wb_mask;
      busy_a   = pend_eff[a_addr] || (ex_valid_q && ex_wr_q && ex_rd_q == a_addr);
      busy_b   = pend_eff[rb] || (ex_valid_q && ex_wr_q && ex_rd_q == rb);
      hazard   = (is_alu || is_br) ? (busy_a || busy_b) : (is_ldi && busy_a);
      val_a    = (BYP && bus.wb_en && bus.wb_addr == a_addr) ? bus.wb_data : rf_q[a_addr];
      val_b    = is_ldi ? '0 : (BYP && bus.wb_en && bus.wb_addr == rb) ? bus.wb_data : rf_q[rb];
   end

   assign in_ready = rst_n && (state_q == RUN) && !bus.flush && !hazard && (!ex_valid_q || bus.ex_ready);
   assign xfer     = bus.in_valid && in_ready;
   assign consume  = ex_valid_q && bus.ex_ready;

   // Scoreboard next state: a consumed writer sets its bit after writeback clears, so set wins
   always_comb begin
      pending_d = pending_q;
      if (bus.wb_en) pending_d[bus.wb_addr] = 1'b0;
      if (consume && ex_wr_q) pending_d[ex_rd_q] = 1'b1;
   end

   // Run/halt control with registered halted and one-cycle illegal pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= xfer && is_illegal;
         if (state_q == RUN && xfer && is_halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
         end
      end
   end

   // Execute bundle: load on issue, hold under backpressure, drop when consumed or flushed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_wr_q    <= 1'b0;
         alu_op_q   <= 1'b0;
         branch_q   <= 1'b0;
         use_imm_q  <= 1'b0;
         shift_q    <= '0;
         imm_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         pc_q       <= '0;
         ex_rd_q    <= '0;
      end else if (xfer && is_bundle) begin
         ex_valid_q <= 1'b1;
         ex_wr_q    <= is_wr;
         alu_op_q   <= (op == 4'd2) || is_br;
         branch_q   <= is_br;
         use_imm_q  <= is_ldi;
         shift_q    <= bus.in_instr[15:14];
         imm_q      <= bus.in_instr[10:0];
         a_q        <= val_a;
         b_q        <= val_b;
         pc_q       <= bus.in_pc;
         ex_rd_q    <= rd;
      end else if (bus.ex_ready || bus.flush) begin
         ex_valid_q <= 1'b0;
      end
   end

   // Pending-write scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending_q <= '0;
      else pending_q <= pending_d;
   end

   // Register file written from the writeback stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (bus.wb_en) begin
         rf_q[bus.wb_addr] <= bus.wb_data;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.ex_valid      = ex_valid_q;
   assign bus.ex_alu_op     = alu_op_q;
   assign bus.ex_branch     = branch_q;
   assign bus.ex_use_imm    = use_imm_q;
   assign bus.ex_shift_dist = shift_q;
   assign bus.ex_imm        = imm_q;
   assign bus.ex_a          = a_q;
   assign bus.ex_b          = b_q;
   assign bus.ex_pc         = pc_q;
   assign bus.ex_rd         = ex_rd_q;
   assign bus.halted        = halted_q;
   assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed tests of decode_issue (reset, ALU, RAW, backpressure, flush, illegal, halt)
module tb_decode_issue;
   logic clk;
   logic rst_n;
   int   pass_cnt = 0;
   int   total = 0;

   decode_issue_if #(.DATAW(32), .PCW(32)) bus ();

   decode_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [1:0] sh, input logic [10:0] imm);
      return {op, rd, ra, rb, sh, 3'b000, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [3:0] addr, input logic [31:0] data);
      bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
      tick();
      bus.wb_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.ex_ready = 0;
      bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.flush = 0;
      #1;
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %0b exp 0", bus.ex_valid); else pass_cnt++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b exp 0", bus.in_ready); else pass_cnt++;
      total++; if (bus.halted !== 1'b0 || bus.illegal !== 1'b0) $display("FAIL reset_flags got %0b%0b exp 00", bus.halted, bus.illegal); else pass_cnt++;
      total++; if (bus.ex_a !== 32'd0 || bus.ex_rd !== 4'd0) $display("FAIL reset_ex_fields got %0h/%0h exp 0/0", bus.ex_a, bus.ex_rd); else pass_cnt++;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      wb(4'd1, 32'd5);
      wb(4'd2, 32'd7);
      bus.in_valid = 1; bus.in_instr = ins(4'd1, 4'd3, 4'd1, 4'd2, 2'd2, 11'h055); bus.in_pc = 32'h100;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL alu_in_ready got %0b exp 1", bus.in_ready); else pass_cnt++;
      tick();
      bus.in_valid = 0;
      total++; if (bus.ex_valid !== 1'b1 || bus.ex_alu_op !== 1'b0) $display("FAIL alu_valid_op got %0b/%0b exp 1/0", bus.ex_valid, bus.ex_alu_op); else pass_cnt++;
      total++; if (bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7) $display("FAIL alu_operands got %0h/%0h exp 5/7", bus.ex_a, bus.ex_b); else pass_cnt++;
      total++; if (bus.ex_rd !== 4'd3 || bus.ex_pc !== 32'h100) $display("FAIL alu_rd_pc got %0h/%0h exp 3/100", bus.ex_rd, bus.ex_pc); else pass_cnt++;
      total++; if (bus.ex_shift_dist !== 2'd2 || bus.ex_imm !== 11'h055 || bus.ex_use_imm !== 1'b0 || bus.ex_branch !== 1'b0)
         $display("FAIL alu_misc got sh=%0d imm=%0h ui=%0b br=%0b exp 2/55/0/0", bus.ex_shift_dist, bus.ex_imm, bus.ex_use_imm, bus.ex_branch); else pass_cnt++;
      bus.ex_ready = 1;
      tick();
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL alu_consumed got %0b exp 0", bus.ex_valid); else pass_cnt++;
   endtask

   task automatic test_raw();
      bus.in_valid = 1; bus.in_instr = ins(4'd2, 4'd4, 4'd3, 4'd1, 2'd0, 11'd0); bus.in_pc = 32'h104;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++; if (bus.in_ready !== 1'b0) $display("FAIL raw_stall%0d got %0b exp 0", i, bus.in_ready); else pass_cnt++;
         tick();
      end
      bus.wb_en = 1; bus.wb_addr = 4'd3; bus.wb_data = 32'd9;
      #1;
`ifdef DECODE_BYPASS_EN
      total++; if (bus.in_ready !== 1'b1) $display("FAIL raw_wb_cycle_ready got %0b exp 1", bus.in_ready); else pass_cnt++;
      tick();
      bus.wb_en = 0;
`else
      total++; if (bus.in_ready !== 1'b0) $display("FAIL raw_wb_cycle_ready got %0b exp 0", bus.in_ready); else pass_cnt++;
      tick();
      bus.wb_en = 0;
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL raw_early_issue got %0b exp 0", bus.ex_valid); else pass_cnt++;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL raw_after_wb_ready got %0b exp 1", bus.in_ready); else pass_cnt++;
      tick();
`endif
      bus.in_valid = 0;
      total++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'd9 || bus.ex_b !== 32'd5 || bus.ex_alu_op !== 1'b1)
         $display("FAIL raw_issue got v=%0b a=%0h b=%0h op=%0b exp 1/9/5/1", bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_alu_op); else pass_cnt++;
      tick();
      wb(4'd4, 32'h44);
   endtask

   task automatic test_backpressure();
      bus.ex_ready = 0;
      bus.in_valid = 1; bus.in_instr = ins(4'd3, 4'd5, 4'd0, 4'd0, 2'd1, 11'h123); bus.in_pc = 32'h108;
      tick();
      bus.in_instr = ins(4'd1, 4'd6, 4'd1, 4'd2, 2'd0, 11'd0); bus.in_pc = 32'h10c;
      total++; if (bus.ex_use_imm !== 1'b1 || bus.ex_imm !== 11'h123 || bus.ex_a !== 32'd0 || bus.ex_rd !== 4'd5)
         $display("FAIL ldi_bundle got ui=%0b imm=%0h a=%0h rd=%0h exp 1/123/0/5", bus.ex_use_imm, bus.ex_imm, bus.ex_a, bus.ex_rd); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (bus.in_ready !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 4'd5 || bus.ex_imm !== 11'h123 || bus.ex_pc !== 32'h108)
            $display("FAIL bp_hold%0d got rdy=%0b v=%0b rd=%0h imm=%0h exp 0/1/5/123", i, bus.in_ready, bus.ex_valid, bus.ex_rd, bus.ex_imm); else pass_cnt++;
         tick();
      end
      bus.ex_ready = 1;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b exp 1", bus.in_ready); else pass_cnt++;
      tick();
      bus.in_valid = 0;
      total++; if (bus.ex_rd !== 4'd6 || bus.ex_a !== 32'd5 || bus.ex_pc !== 32'h10c)
         $display("FAIL bp_next_issue got rd=%0h a=%0h pc=%0h exp 6/5/10c", bus.ex_rd, bus.ex_a, bus.ex_pc); else pass_cnt++;
      tick();
   endtask

   task automatic test_flush();
      bus.ex_ready = 0;
      bus.in_valid = 1; bus.in_instr = ins(4'd1, 4'd7, 4'd1, 4'd2, 2'd0, 11'd0); bus.in_pc = 32'h110;
      tick();
      bus.in_instr = ins(4'd1, 4'd8, 4'd1, 4'd2, 2'd0, 11'd0); bus.in_pc = 32'h114;
      bus.flush = 1;
      #1;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_ready got %0b exp 0", bus.in_ready); else pass_cnt++;
      tick();
      bus.flush = 0; bus.in_valid = 0;
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL flush_kill got %0b exp 0", bus.ex_valid); else pass_cnt++;
      bus.ex_ready = 1;
      bus.in_valid = 1; bus.in_instr = ins(4'd1, 4'd9, 4'd7, 4'd1, 2'd0, 11'd0); bus.in_pc = 32'h118;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_no_pending got %0b exp 1", bus.in_ready); else pass_cnt++;
      tick();
      bus.in_valid = 0;
      total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 4'd9 || bus.ex_pc !== 32'h118)
         $display("FAIL flush_next_issue got v=%0b rd=%0h pc=%0h exp 1/9/118", bus.ex_valid, bus.ex_rd, bus.ex_pc); else pass_cnt++;
      tick();
   endtask

   task automatic test_illegal_branch();
      bus.in_valid = 1; bus.in_instr = ins(4'd9, 4'd1, 4'd1, 4'd1, 2'd0, 11'd0);
      tick();
      bus.in_instr = ins(4'd0, 4'd1, 4'd1, 4'd1, 2'd0, 11'd0);
      total++; if (bus.illegal !== 1'b1 || bus.ex_valid !== 1'b0) $display("FAIL illegal_pulse got ill=%0b v=%0b exp 1/0", bus.illegal, bus.ex_valid); else pass_cnt++;
      tick();
      bus.in_instr = ins(4'd4, 4'd0, 4'd1, 4'd2, 2'd3, 11'h7ff); bus.in_pc = 32'h200;
      total++; if (bus.illegal !== 1'b0 || bus.ex_valid !== 1'b0) $display("FAIL nop_drop got ill=%0b v=%0b exp 0/0", bus.illegal, bus.ex_valid); else pass_cnt++;
      tick();
      bus.in_instr = ins(4'd1, 4'd10, 4'd0, 4'd1, 2'd0, 11'd0); bus.in_pc = 32'h204;
      total++; if (bus.ex_branch !== 1'b1 || bus.ex_alu_op !== 1'b1 || bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7 || bus.ex_shift_dist !== 2'd3)
         $display("FAIL br_bundle got br=%0b op=%0b a=%0h b=%0h sh=%0d exp 1/1/5/7/3", bus.ex_branch, bus.ex_alu_op, bus.ex_a, bus.ex_b, bus.ex_shift_dist); else pass_cnt++;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL br_no_write_ready got %0b exp 1", bus.in_ready); else pass_cnt++;
      tick();
      bus.in_valid = 0;
      tick();
   endtask

   task automatic test_halt();
      bus.in_valid = 1; bus.in_instr = ins(4'd5, 4'd0, 4'd0, 4'd0, 2'd0, 11'd0);
      tick();
      bus.in_instr = ins(4'd1, 4'd11, 4'd1, 4'd2, 2'd0, 11'd0);
      total++; if (bus.halted !== 1'b1 || bus.ex_valid !== 1'b0) $display("FAIL halt_state got h=%0b v=%0b exp 1/0", bus.halted, bus.ex_valid); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (bus.in_ready !== 1'b0 || bus.ex_valid !== 1'b0) $display("FAIL halt_block%0d got rdy=%0b v=%0b exp 0/0", i, bus.in_ready, bus.ex_valid); else pass_cnt++;
         tick();
      end
      bus.flush = 1;
      tick();
      bus.flush = 0;
      total++; if (bus.halted !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL halt_flush got h=%0b rdy=%0b exp 1/0", bus.halted, bus.in_ready); else pass_cnt++;
      bus.in_valid = 0;
   endtask

   task automatic test_reset_mid();
      rst_n = 0;
      #1;
      total++; if (bus.halted !== 1'b0) $display("FAIL rst_halted got %0b exp 0", bus.halted); else pass_cnt++;
      tick();
      rst_n = 1;
      bus.ex_ready = 0;
      bus.in_valid = 1; bus.in_instr = ins(4'd1, 4'd3, 4'd1, 4'd2, 2'd0, 11'd0); bus.in_pc = 32'h300;
      tick();
      bus.in_valid = 0;
      total++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'd0) $display("FAIL rst_rf_clear got v=%0b a=%0h exp 1/0", bus.ex_valid, bus.ex_a); else pass_cnt++;
      #3;
      rst_n = 0;
      #1;
      total++; if (bus.ex_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.halted !== 1'b0)
         $display("FAIL rst_async got v=%0b rdy=%0b h=%0b exp 0/0/0", bus.ex_valid, bus.in_ready, bus.halted); else pass_cnt++;
      tick();
      rst_n = 1;
      bus.in_valid = 1; bus.in_instr = ins(4'd1, 4'd12, 4'd5, 4'd6, 2'd0, 11'd0);
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_pending_clear got %0b exp 1", bus.in_ready); else pass_cnt++;
      bus.in_valid = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_raw();
      test_backpressure();
      test_flush();
      test_illegal_branch();
      test_halt();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
